// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Uses a req/ready handshake; a completing read returns its word on dmem_rdata.
interface mem_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     dmem_req;
    logic                     dmem_we;
    logic [ADDRESS_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0]    dmem_wdata;
    logic [3:0]               dmem_be;
    logic                     dmem_ready;
    logic [DATA_WIDTH-1:0]    dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data-memory bus, aligns stores, extends
// loads, stalls upstream while memory is busy, and registers the M->W bundle.
module mem_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [DATA_WIDTH-1:0]    m_aluresult,
    input  logic [DATA_WIDTH-1:0]    m_wdata,
    input  logic [4:0]               m_rd,
    input  logic [ADDRESS_WIDTH-1:0] m_pcplus4,
    input  logic                     m_regwrite,
    input  logic                     m_memwrite,
    input  logic [1:0]               m_resultsrc,
    input  logic [2:0]               m_funct3,

    mem_stage_if.master              dmem,

    output logic                     m_stall,

    output logic [DATA_WIDTH-1:0]    w_aluresult,
    output logic [DATA_WIDTH-1:0]    w_readdata,
    output logic [4:0]               w_rd,
    output logic [ADDRESS_WIDTH-1:0] w_pcplus4,
    output logic                     w_regwrite,
    output logic [1:0]               w_resultsrc,
    output logic                     w_fault
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_RSVD = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ------------------------------------------------------------------
    // Access decode and fault detection
    // ------------------------------------------------------------------
    logic is_store;
    logic is_load;
    logic access;
    logic funct3_legal;
    logic misaligned;
    logic fault;
    logic legal_access;
    logic load_done;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the missing case.
    always_comb begin
        is_store = m_memwrite;
        is_load  = !m_memwrite && (m_resultsrc == RES_LOAD);
        access   = is_store || is_load;

        funct3_legal = 1'b0;
        case (m_funct3)
            F3_B, F3_H, F3_W: funct3_legal = 1'b1;
            F3_BU, F3_HU:     funct3_legal = is_load;
            default:          funct3_legal = 1'b0;
        endcase

        // funct3[1:0] encodes access size for every legal load/store
        misaligned = ((m_funct3[1:0] == 2'b01) && m_aluresult[0]) ||
                     ((m_funct3[1:0] == 2'b10) && (m_aluresult[1:0] != 2'b00));

        fault        = access && (!funct3_legal || misaligned);
        legal_access = access && !fault;
        load_done    = legal_access && is_load && dmem.dmem_ready;
    end

    // Request and stall are gated by reset so an abandoned access drops at once
    assign dmem.dmem_req = legal_access && rst_n;
    assign m_stall       = legal_access && !dmem.dmem_ready && rst_n;
    assign dmem.dmem_we  = is_store;
    assign dmem.dmem_addr = {m_aluresult[ADDRESS_WIDTH-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Store lane alignment
    // ------------------------------------------------------------------
    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = m_wdata;
        if (is_store) begin
            case (m_funct3[1:0])
                2'b00: begin
                    dmem.dmem_be    = 4'b0001 << m_aluresult[1:0];
                    dmem.dmem_wdata = {4{m_wdata[7:0]}};
                end
                2'b01: begin
                    dmem.dmem_be    = m_aluresult[1] ? 4'b1100 : 4'b0011;
                    dmem.dmem_wdata = {2{m_wdata[15:0]}};
                end
                default: begin
                    dmem.dmem_be    = 4'b1111;
                    dmem.dmem_wdata = m_wdata;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        case (m_aluresult[1:0])
            2'b00:   load_byte = dmem.dmem_rdata[7:0];
            2'b01:   load_byte = dmem.dmem_rdata[15:8];
            2'b10:   load_byte = dmem.dmem_rdata[23:16];
            default: load_byte = dmem.dmem_rdata[31:24];
        endcase
        load_half = m_aluresult[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

        case (m_funct3)
            F3_B:    load_ext = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_ext = {{16{load_half[15]}}, load_half};
            F3_BU:   load_ext = {24'd0, load_byte};
            F3_HU:   load_ext = {16'd0, load_half};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (legal_access && !dmem.dmem_ready) state_d = WAIT;
            WAIT:    if (!legal_access || dmem.dmem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory -> writeback register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    w_aluresult_q, w_aluresult_d;
    logic [DATA_WIDTH-1:0]    w_readdata_q,  w_readdata_d;
    logic [4:0]               w_rd_q,        w_rd_d;
    logic [ADDRESS_WIDTH-1:0] w_pcplus4_q,   w_pcplus4_d;
    logic                     w_regwrite_q,  w_regwrite_d;
    logic [1:0]               w_resultsrc_q, w_resultsrc_d;
    logic                     w_fault_q,     w_fault_d;

    always_comb begin
        // A stall inserts a bubble; payload fields simply hold
        w_aluresult_d = w_aluresult_q;
        w_readdata_d  = w_readdata_q;
        w_rd_d        = w_rd_q;
        w_pcplus4_d   = w_pcplus4_q;
        w_resultsrc_d = w_resultsrc_q;
        w_regwrite_d  = 1'b0;
        w_fault_d     = 1'b0;
        if (!m_stall) begin
            w_aluresult_d = m_aluresult;
            w_readdata_d  = load_done ? load_ext : '0;
            w_rd_d        = m_rd;
            w_pcplus4_d   = m_pcplus4;
            w_resultsrc_d = (m_resultsrc == RES_RSVD) ? RES_ALU : m_resultsrc;
            w_regwrite_d  = m_regwrite && !fault;
            w_fault_d     = fault;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            w_aluresult_q <= '0;
            w_readdata_q  <= '0;
            w_rd_q        <= '0;
            w_pcplus4_q   <= '0;
            w_regwrite_q  <= 1'b0;
            w_resultsrc_q <= '0;
            w_fault_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_aluresult_q <= w_aluresult_d;
            w_readdata_q  <= w_readdata_d;
            w_rd_q        <= w_rd_d;
            w_pcplus4_q   <= w_pcplus4_d;
            w_regwrite_q  <= w_regwrite_d;
            w_resultsrc_q <= w_resultsrc_d;
            w_fault_q     <= w_fault_d;
        end
    end

    assign w_aluresult = w_aluresult_q;
    assign w_readdata  = w_readdata_q;
    assign w_rd        = w_rd_q;
    assign w_pcplus4   = w_pcplus4_q;
    assign w_regwrite  = w_regwrite_q;
    assign w_resultsrc = w_resultsrc_q;
    assign w_fault     = w_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues directed and random accesses
// and queues the expected W bundle; a monitor pops and compares it.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] m_aluresult, m_wdata, m_pcplus4;
    logic [4:0]  m_rd;
    logic        m_regwrite, m_memwrite;
    logic [1:0]  m_resultsrc;
    logic [2:0]  m_funct3;
    logic        m_stall;
    logic [31:0] w_aluresult, w_readdata, w_pcplus4;
    logic [4:0]  w_rd;
    logic        w_regwrite, w_fault;
    logic [1:0]  w_resultsrc;

    mem_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dmem ();

    mem_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_aluresult (m_aluresult),
        .m_wdata     (m_wdata),
        .m_rd        (m_rd),
        .m_pcplus4   (m_pcplus4),
        .m_regwrite  (m_regwrite),
        .m_memwrite  (m_memwrite),
        .m_resultsrc (m_resultsrc),
        .m_funct3    (m_funct3),
        .dmem        (dmem.master),
        .m_stall     (m_stall),
        .w_aluresult (w_aluresult),
        .w_readdata  (w_readdata),
        .w_rd        (w_rd),
        .w_pcplus4   (w_pcplus4),
        .w_regwrite  (w_regwrite),
        .w_resultsrc (w_resultsrc),
        .w_fault     (w_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, wdata, pc4, rdata;
        logic [4:0]  rd;
        logic        regwrite, memwrite;
        logic [1:0]  rs;
        logic [2:0]  f3;
        int          nwait;
    } instr_t;

    typedef struct {
        logic [31:0] alu, rdata, pc4;
        logic [4:0]  rd;
        logic        regwrite, fault;
        logic [1:0]  rs;
    } wexp_t;

    wexp_t scoreboard[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_access(instr_t t);
        return t.memwrite || (t.rs == 2'b01);
    endfunction

    function automatic bit f3_ok(instr_t t);
        if (t.memwrite) return t.f3 <= 3'd2;
        return (t.f3 <= 3'd2) || (t.f3 == 3'd4) || (t.f3 == 3'd5);
    endfunction

    function automatic int size_of(logic [2:0] f3);
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 1;
    endfunction

    function automatic bit faults(instr_t t);
        if (!is_access(t)) return 1'b0;
        if (!f3_ok(t)) return 1'b1;
        return (t.addr % size_of(t.f3)) != 0;
    endfunction

    function automatic logic [31:0] ext_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        int unsigned off = a % 4;
        logic [31:0] b = (w >> (8 * off)) & 32'hFF;
        logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic wexp_t model_w(instr_t t);
        wexp_t e;
        bit f = faults(t);
        e.alu      = t.addr;
        e.pc4      = t.pc4;
        e.rd       = t.rd;
        e.regwrite = t.regwrite && !f;
        e.fault    = f;
        e.rs       = (t.rs == 2'b11) ? 2'b00 : t.rs;
        e.rdata    = (!t.memwrite && t.rs == 2'b01 && !f) ? ext_load(t.f3, t.addr, t.rdata) : 32'd0;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_inputs(instr_t t);
        m_aluresult = t.addr;
        m_wdata     = t.wdata;
        m_rd        = t.rd;
        m_pcplus4   = t.pc4;
        m_regwrite  = t.regwrite;
        m_memwrite  = t.memwrite;
        m_resultsrc = t.rs;
        m_funct3    = t.f3;
    endtask

    // Starts and ends on a falling edge; pushes the expectation on the completing cycle.
    task automatic run_instr(instr_t t);
        bit legal = is_access(t) && !faults(t);
        int n     = legal ? t.nwait : 0;
        logic [3:0]  be_exp;
        logic [31:0] wd_exp;
        if (t.memwrite && t.f3 == 3'd0) begin
            be_exp = 4'(1 << (t.addr % 4));
            wd_exp = (t.wdata & 32'hFF) * 32'h01010101;
        end else if (t.memwrite && t.f3 == 3'd1) begin
            be_exp = 4'(3 << (2 * ((t.addr % 4) / 2)));
            wd_exp = (t.wdata & 32'hFFFF) * 32'h00010001;
        end else begin
            be_exp = 4'hF;
            wd_exp = t.wdata;
        end
        for (int c = 0; c <= n; c++) begin
            drive_inputs(t);
            dmem.dmem_ready = legal ? (c == n) : 1'($urandom_range(0, 1));
            dmem.dmem_rdata = (c == n) ? t.rdata : $urandom;
            if (c == n) scoreboard.push_back(model_w(t));
            #1;
            check("dmem_req", {31'd0, dmem.dmem_req}, {31'd0, legal});
            check("m_stall", {31'd0, m_stall}, {31'd0, legal && (c < n)});
            if (legal) begin
                check("dmem_addr", dmem.dmem_addr, t.addr & 32'hFFFF_FFFC);
                check("dmem_we", {31'd0, dmem.dmem_we}, {31'd0, t.memwrite});
                check("dmem_be", {28'd0, dmem.dmem_be}, {28'd0, be_exp});
                if (t.memwrite) check("dmem_wdata", dmem.dmem_wdata, wd_exp);
            end
            @(negedge clk);
        end
    endtask

    function automatic instr_t mk(bit st, logic [1:0] rs, logic [2:0] f3, logic [31:0] addr,
                                  logic [31:0] wdata, logic [31:0] rdata, logic [4:0] rd, int nwait);
        instr_t t;
        t.memwrite = st;
        t.rs       = rs;
        t.f3       = f3;
        t.addr     = addr;
        t.wdata    = wdata;
        t.rdata    = rdata;
        t.rd       = rd;
        t.regwrite = !st;
        t.pc4      = addr + 32'h1000;
        t.nwait    = nwait;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int k = $urandom_range(0, 2);
        logic [2:0] legal_ld[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        t.addr     = $urandom;
        t.wdata    = $urandom;
        t.rdata    = $urandom;
        t.pc4      = $urandom;
        t.rd       = 5'($urandom);
        t.regwrite = 1'($urandom_range(0, 1));
        t.nwait    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3);
        if (k == 0) begin
            t.memwrite = 1'b0;
            t.rs       = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
            t.f3       = 3'($urandom);
        end else if (k == 1) begin
            t.memwrite = 1'b0;
            t.rs       = 2'b01;
            t.f3       = ($urandom_range(0, 9) < 8) ? legal_ld[$urandom_range(0, 4)] : 3'($urandom);
        end else begin
            t.memwrite = 1'b1;
            t.rs       = 2'b00;
            t.f3       = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
        end
        if ($urandom_range(0, 3) != 0)
            t.addr = t.addr - (t.addr % size_of(t.f3));
        return t;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        bit    was_rst, was_stall;
        wexp_t e;
        forever begin
            @(negedge clk);
            #2;
            was_rst   = !rst_n;
            was_stall = m_stall;
            @(posedge clk);
            #1;
            if (!was_rst) begin
                if (was_stall) begin
                    check("bubble_regwrite", {31'd0, w_regwrite}, 32'd0);
                    check("bubble_fault", {31'd0, w_fault}, 32'd0);
                end else if (scoreboard.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected: W bundle with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = scoreboard.pop_front();
                    check("w_regwrite", {31'd0, w_regwrite}, {31'd0, e.regwrite});
                    check("w_fault", {31'd0, w_fault}, {31'd0, e.fault});
                    check("w_aluresult", w_aluresult, e.alu);
                    check("w_readdata", w_readdata, e.rdata);
                    check("w_rd", {27'd0, w_rd}, {27'd0, e.rd});
                    check("w_pcplus4", w_pcplus4, e.pc4);
                    check("w_resultsrc", {30'd0, w_resultsrc}, {30'd0, e.rs});
                end
            end
        end
    end

    task automatic check_w_zero(input string tag);
        check({tag, "_w_aluresult"}, w_aluresult, 32'd0);
        check({tag, "_w_readdata"}, w_readdata, 32'd0);
        check({tag, "_w_rd"}, {27'd0, w_rd}, 32'd0);
        check({tag, "_w_pcplus4"}, w_pcplus4, 32'd0);
        check({tag, "_w_regwrite"}, {31'd0, w_regwrite}, 32'd0);
        check({tag, "_w_resultsrc"}, {30'd0, w_resultsrc}, 32'd0);
        check({tag, "_w_fault"}, {31'd0, w_fault}, 32'd0);
    endtask

    // lw stuck in WAIT, reset pulsed in its third cycle
    task automatic reset_mid_wait();
        instr_t t = mk(1'b0, 2'b01, 3'd2, 32'h300, 32'd0, 32'h1234_5678, 5'd7, 5);
        for (int c = 0; c < 3; c++) begin
            drive_inputs(t);
            dmem.dmem_ready = 1'b0;
            dmem.dmem_rdata = $urandom;
            #1;
            check("rstwait_stall", {31'd0, m_stall}, 32'd1);
            if (c == 2) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rstwait_req", {31'd0, dmem.dmem_req}, 32'd0);
                check("rstwait_stall_drop", {31'd0, m_stall}, 32'd0);
                check_w_zero("rstwait");
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t dir[$];
        rst_n = 1'b0;
        drive_inputs(mk(1'b0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0));
        m_regwrite      = 1'b0;
        m_pcplus4       = 32'd0;
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req", {31'd0, dmem.dmem_req}, 32'd0);
        check_w_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        dir.push_back(mk(1'b1, 2'b00, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'd0, 5'd0, 0));
        dir.push_back(mk(1'b1, 2'b00, 3'd0, 32'h103, 32'h0000_00A5, 32'd0, 5'd0, 0));
        dir.push_back(mk(1'b0, 2'b01, 3'd0, 32'h202, 32'd0, 32'h0080_FF00, 5'd5, 0));
        dir.push_back(mk(1'b0, 2'b01, 3'd4, 32'h202, 32'd0, 32'h0080_FF00, 5'd6, 0));
        dir.push_back(mk(1'b0, 2'b01, 3'd2, 32'h204, 32'd0, 32'hCAFE_F00D, 5'd9, 3));
        dir.push_back(mk(1'b0, 2'b01, 3'd1, 32'h101, 32'd0, 32'h1111_2222, 5'd3, 2));
        dir.push_back(mk(1'b0, 2'b01, 3'd3, 32'h100, 32'd0, 32'h3333_4444, 5'd4, 2));
        dir.push_back(mk(1'b1, 2'b00, 3'd1, 32'h106, 32'h0000_BEEF, 32'd0, 5'd0, 1));
        dir.push_back(mk(1'b0, 2'b10, 3'd0, 32'h400, 32'd0, 32'd0, 5'd1, 0));
        foreach (dir[i]) run_instr(dir[i]);

        reset_mid_wait();
        run_instr(mk(1'b0, 2'b01, 3'd5, 32'h302, 32'd0, 32'h8001_0000, 5'd8, 0));

        for (int i = 0; i < 400; i++) run_instr(rand_instr());

        #1;
        check("scoreboard_empty", scoreboard.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
